fm_to_low_clock: RTL and testbench
==================================

Name: fm_to_low_clock

Overview:
- Moves filtered FM audio samples from the fast `clock_high` domain into the slow `clock_low` domain.
- Runs entirely on `clock_high`; `clock_low` is treated only as a sampled level input.
- Averages a fixed power-of-two window of input samples and stages each result.
- Updates `data_out` only just after a detected `clock_low` falling edge, so the value is stable across the following `clock_low` rising edge, where low-domain logic samples it.

Parameters:
- DATA_WIDTH, 16, width of signed sample in and out.
- AVG_SHIFT, 2, averaging window = 2^AVG_SHIFT valid samples (legal 0..4).

Ports:
- clock_high  in  1  only clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high, sampled on clock_high.
- clock_low  in  1  slow clock, used as a data level only; synchronised internally.
- data_in  in  DATA_WIDTH  signed sample, two's complement.
- data_valid  in  1  data_in is consumed on this cycle.
- data_out  out  DATA_WIDTH  signed averaged sample, held between updates.
- out_update  out  1  single-cycle pulse, coincident with each data_out change.
- overrun  out  1  sticky: a staged result was overwritten before transfer.

Behaviour:
- Reset: data_out=0, out_update=0, overrun=0, accumulator=0, sample count=0, pending_valid=0, pending=0, all clock_low sync flops=0.
  - Reset mid-window discards the partial sum. It has priority over every other event.
  - With the sync flops cleared to 0, no false falling edge can be detected after reset.
- Sync and edge detect:
  - Three-flop chain s1<=clock_low, s2<=s1, s3<=s2.
  - fall = s3 & ~s2.
  - First posedge that samples clock_low=0 is cycle T. fall is asserted combinationally in T+2 and acts at the T+2 edge, so data_out and out_update take effect from cycle T+3.
- Edge FSM, two states:
  - WAIT_LOW: on fall -> WAIT_HIGH.
  - WAIT_HIGH: on s2=1 -> WAIT_LOW.
  - Transfer is allowed only on the WAIT_LOW->WAIT_HIGH transition, so there is at most one transfer per clock_low period even if clock_low glitches.
- Accumulate:
  - Each data_valid cycle: acc += sign-extended data_in; count += 1.
  - acc width = DATA_WIDTH+AVG_SHIFT signed, so overflow is impossible.
  - When count reaches 2^AVG_SHIFT-1 and data_valid=1 (window complete):
    - result = (acc + data_in) >>> AVG_SHIFT, arithmetic shift (floor). The result always fits in DATA_WIDTH, so no saturation.
    - acc and count restart at 0 on the next cycle.
  - AVG_SHIFT=0: every valid sample is a complete window.
- Staging and transfer, same cycle:
  - Transfer fires if the fall transition is taken AND pending_valid was 1 before this edge.
    - On transfer: data_out<=pending, out_update<=1, pending_valid<=0.
  - If a window completes: pending<=result, pending_valid<=1.
    - This overrides the clear from a same-cycle transfer; the new result waits for the next edge.
  - Window completes while pending_valid=1 and no same-cycle transfer: pending is overwritten by the newer result and overrun<=1.
- Edge with pending_valid=0: data_out holds, out_update=0.
- overrun clears only on reset.
- data_valid during reset is ignored.

Decomposition:
- Package fm_filter_pkg: DATA_WIDTH default, AVG_SHIFT default, sync depth constant (3), edge-FSM state encoding (WAIT_LOW=0, WAIT_HIGH=1).
- One sub-module, low_clock_edge_detect:
  - Contains the 3-flop sync, the edge FSM, and the `fall` output.
  - Same reset rules as the parent.

Test Plan:
1. AVG_SHIFT=2; valid samples 4,8,12,16 back-to-back; then clock_low 1->0 -> pending=10; data_out=10 with out_update pulse exactly 3 clock_high cycles after the first sample of clock_low=0.
2. Samples -1,-2,-3,-4 -> data_out=-3 (floor of -2.5). Samples 32767 x4 -> 32767. Samples -32768 x4 -> -32768. No overrun.
3. Two full windows (results 10 then 20) before any clock_low fall -> overrun=1; next fall transfers 20; overrun stays 1 until reset.
4. Window completes in the same cycle the fall transition is taken, with pending=10 already staged -> data_out=10 now; new result stays pending; the following fall transfers it.
5. Two valid samples of 500, reset for 1 cycle, then four samples of 100 -> data_out=100; overrun=0; no out_update before the first post-reset fall.
6. clock_low held low for 20 cycles, or clock_low glitch 0-1-0 shorter than the sync depth -> exactly one out_update per clock_low period.

Source files
------------

// File: rtl/fm_filter_pkg.sv
// Shared constants and types for the FM audio to low-clock transfer block.
package fm_filter_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int AVG_SHIFT_DEF  = 2;
    localparam int SYNC_DEPTH     = 3;

    // Edge FSM: transfer is armed in WAIT_LOW and disarmed until clock_low is seen high again.
    typedef enum logic {
        WAIT_LOW  = 1'b0,
        WAIT_HIGH = 1'b1
    } edge_state_e;

endpackage

// File: rtl/fm_to_low_clock_if.sv
// Sample stream into the block and averaged, low-clock-aligned result out.
interface fm_to_low_clock_if
    import fm_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_valid;
    logic signed [DATA_WIDTH-1:0] data_out;
    logic                         out_update;
    logic                         overrun;

    modport master (
        output data_in,
        output data_valid,
        input  data_out,
        input  out_update,
        input  overrun
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_out,
        output out_update,
        output overrun
    );

endinterface

// File: rtl/low_clock_edge_detect.sv
// Synchronises clock_low into the clock_high domain, flags its falling edge and
// tracks whether a transfer is still allowed in the current clock_low period.
module low_clock_edge_detect
    import fm_filter_pkg::*;
(
    input  logic        clock_high_i,
    input  logic        reset_i,
    input  logic        clock_low_i,
    output logic        fall_o,
    output edge_state_e state_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    edge_state_e           state_q;

    // Oldest flop still 1 while the next one has gone 0: falling edge of clock_low.
    assign fall_o  = sync_q[SYNC_DEPTH-1] & ~sync_q[SYNC_DEPTH-2];
    assign state_o = state_q;

    // Synchroniser chain s1 <= clock_low, s2 <= s1, s3 <= s2 plus edge FSM.
    always_ff @(posedge clock_high_i) begin
        if (reset_i) begin
            sync_q  <= '0;
            state_q <= WAIT_LOW;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], clock_low_i};
            case (state_q)
                WAIT_LOW:  if (fall_o)      state_q <= WAIT_HIGH;
                WAIT_HIGH: if (sync_q[1])   state_q <= WAIT_LOW;
                default:                    state_q <= WAIT_LOW;
            endcase
        end
    end

endmodule

// File: rtl/fm_to_low_clock.sv
// Averages windows of 2^AVG_SHIFT FM samples on clock_high and presents each
// result on data_out just after a clock_low falling edge, so it is stable at
// the following clock_low rising edge.
module fm_to_low_clock
    import fm_filter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int AVG_SHIFT  = AVG_SHIFT_DEF
) (
    input  logic              clock_high,
    input  logic              reset,
    input  logic              clock_low,
    fm_to_low_clock_if.slave  bus
);

    localparam int ACC_W = DATA_WIDTH + AVG_SHIFT;
    localparam int CNT_W = AVG_SHIFT + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_SHIFT) - 1);

    // Floor average of a full window; the shifted sum always fits DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] avg_window(input logic signed [ACC_W-1:0] s);
        return DATA_WIDTH'(s >>> AVG_SHIFT);
    endfunction

    logic                         fall;
    edge_state_e                  edge_state;

    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] pending_q, pending_d;
    logic                         pending_valid_q, pending_valid_d;
    logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                         out_update_q, out_update_d;
    logic                         overrun_q, overrun_d;

    logic signed [ACC_W-1:0]      din_ext;
    logic signed [ACC_W-1:0]      sum;
    logic signed [DATA_WIDTH-1:0] result;
    logic                         win_done;
    logic                         transfer;

    low_clock_edge_detect u_edge (
        .clock_high_i (clock_high),
        .reset_i      (reset),
        .clock_low_i  (clock_low),
        .fall_o       (fall),
        .state_o      (edge_state)
    );

    assign din_ext  = ACC_W'(bus.data_in);
    assign sum      = acc_q + din_ext;
    assign result   = avg_window(sum);
    assign win_done = bus.data_valid && (cnt_q == CNT_LAST);
    // Only the WAIT_LOW -> WAIT_HIGH transition may move a staged result out.
    assign transfer = fall && (edge_state == WAIT_LOW) && pending_valid_q;

    // Next-state for accumulator, staging register and output register.
    always_comb begin
        acc_d           = acc_q;
        cnt_d           = cnt_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        data_out_d      = data_out_q;
        out_update_d    = transfer;
        overrun_d       = overrun_q;

        if (bus.data_valid) begin
            if (win_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (transfer) begin
            data_out_d      = pending_q;
            pending_valid_d = 1'b0;
        end

        // A freshly completed window re-arms the stage even if it was just emptied.
        if (win_done) begin
            pending_d       = result;
            pending_valid_d = 1'b1;
            if (pending_valid_q && !transfer) begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers; reset discards any partial window and staged result.
    always_ff @(posedge clock_high) begin
        if (reset) begin
            acc_q           <= '0;
            cnt_q           <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            data_out_q      <= '0;
            out_update_q    <= 1'b0;
            overrun_q       <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            data_out_q      <= data_out_d;
            out_update_q    <= out_update_d;
            overrun_q       <= overrun_d;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.out_update = out_update_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fm_to_low_clock.sv
// Directed bench for fm_to_low_clock with DATA_WIDTH=16, AVG_SHIFT=2.
module tb_fm_to_low_clock;

    logic clock_high = 1'b0;
    logic reset      = 1'b1;
    logic clock_low  = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int upd_cnt  = 0;

    fm_to_low_clock_if #(.DATA_WIDTH(16)) bus ();

    fm_to_low_clock #(
        .DATA_WIDTH (16),
        .AVG_SHIFT  (2)
    ) dut (
        .clock_high (clock_high),
        .reset      (reset),
        .clock_low  (clock_low),
        .bus        (bus)
    );

    always #5 clock_high = ~clock_high;

    always @(negedge clock_high) begin
        if (bus.out_update) upd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_high);
        #1;
    endtask

    task automatic send(input int v);
        bus.data_in    = 16'(v);
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
    endtask

    task automatic window(input int a, input int b, input int c, input int d);
        send(a); send(b); send(c); send(d);
    endtask

    // Edge T samples clock_low=0; update visible right after edge T+2.
    task automatic fall_check(input string tag, input int exp);
        clock_low = 1'b0;
        tick();
        check_val({tag, "_upd_T"}, int'(bus.out_update), 0);
        tick();
        check_val({tag, "_upd_T1"}, int'(bus.out_update), 0);
        tick();
        check_val({tag, "_upd_T2"}, int'(bus.out_update), 1);
        check_val({tag, "_data"}, int'(bus.data_out), exp);
        tick();
        check_val({tag, "_upd_T3"}, int'(bus.out_update), 0);
        clock_low = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int base;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check_val("rst_data_out", int'(bus.data_out), 0);
        check_val("rst_out_update", int'(bus.out_update), 0);
        check_val("rst_overrun", int'(bus.overrun), 0);
        repeat (4) tick();
        check_val("rst_no_false_edge", upd_cnt, 0);

        // Basic average and edge latency.
        window(4, 8, 12, 16);
        fall_check("t1", 10);

        // Floor rounding and extremes.
        window(-1, -2, -3, -4);
        fall_check("t2_neg", -3);
        window(32767, 32767, 32767, 32767);
        fall_check("t2_max", 32767);
        window(-32768, -32768, -32768, -32768);
        fall_check("t2_min", -32768);
        check_val("t2_overrun", int'(bus.overrun), 0);

        // Overwrite of a staged result.
        window(4, 8, 12, 16);
        window(8, 16, 24, 32);
        check_val("t3_overrun_set", int'(bus.overrun), 1);
        fall_check("t3", 20);
        check_val("t3_overrun_sticky", int'(bus.overrun), 1);
        base = upd_cnt;
        clock_low = 1'b0;
        repeat (5) tick();
        check_val("t3_empty_edge_upd", upd_cnt - base, 0);
        check_val("t3_empty_edge_data", int'(bus.data_out), 20);
        clock_low = 1'b1;
        repeat (4) tick();

        // Window completes on the same edge as the transfer.
        window(4, 8, 12, 16);
        send(4); send(4); send(4);
        clock_low = 1'b0;
        tick();
        tick();
        bus.data_in    = 16'sd4;
        bus.data_valid = 1'b1;
        tick();
        bus.data_valid = 1'b0;
        check_val("t4_upd", int'(bus.out_update), 1);
        check_val("t4_data", int'(bus.data_out), 10);
        tick();
        clock_low = 1'b1;
        repeat (4) tick();
        fall_check("t4_next", 4);

        // Reset mid-window, with data_valid held during reset.
        send(500); send(500);
        bus.data_in    = 16'sd500;
        bus.data_valid = 1'b1;
        reset          = 1'b1;
        tick();
        reset          = 1'b0;
        bus.data_valid = 1'b0;
        check_val("t5_overrun_clr", int'(bus.overrun), 0);
        check_val("t5_data_clr", int'(bus.data_out), 0);
        base = upd_cnt;
        repeat (4) tick();
        window(100, 100, 100, 100);
        check_val("t5_no_early_upd", upd_cnt - base, 0);
        fall_check("t5", 100);
        check_val("t5_overrun", int'(bus.overrun), 0);

        // clock_low held low with a sub-cycle glitch: one update per period.
        window(1, 2, 3, 6);
        base = upd_cnt;
        clock_low = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 8 && i < 12) begin
                bus.data_in    = 16'sd7;
                bus.data_valid = 1'b1;
            end else begin
                bus.data_valid = 1'b0;
            end
            if (i == 14) begin
                #2 clock_low = 1'b1;
                #2 clock_low = 1'b0;
            end
            tick();
        end
        bus.data_valid = 1'b0;
        check_val("t6_one_update", upd_cnt - base, 1);
        check_val("t6_data_held", int'(bus.data_out), 3);
        check_val("t6_overrun", int'(bus.overrun), 0);
        clock_low = 1'b1;
        repeat (4) tick();
        fall_check("t6_next", 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
